// File: rtl/ulbf_master_tx.sv
// Transmit side of the ulbf link: a TX RAM loaded over a BRAM-style port,
// streamed out on AXI4-Stream niter times with tlast closing every pass.
module ulbf_master_tx #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 12,
    parameter int NITER_WIDTH = 12
) (
    input  logic                   m_axis_clk,
    input  logic                   master_rst,
    input  logic                   start,
    input  logic [NITER_WIDTH-1:0] niter,
    input  logic [ADDR_WIDTH:0]    block_len,
    input  logic                   enb,
    input  logic                   web,
    input  logic [ADDR_WIDTH-1:0]  addrb,
    input  logic [DATA_WIDTH-1:0]  dinb,
    output logic [DATA_WIDTH-1:0]  doutb,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [3:0]             current_state,
    output logic [15:0]            txram_counter,
    output logic                   txdone
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_PREFETCH = 4'd1,
        S_STREAM   = 4'd2,
        S_DONE     = 4'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]    BLEN_ONE  = 1;
    localparam logic [NITER_WIDTH-1:0] NITER_ONE = 1;

    logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];

    state_t                 state_q;
    logic [NITER_WIDTH-1:0] niter_q;
    logic [NITER_WIDTH-1:0] pass_q;
    logic [ADDR_WIDTH:0]    blen_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic                   issue_done_q;

    logic                   rd_vld_q;
    logic                   rd_last_q;
    logic                   rd_final_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;

    logic [DATA_WIDTH-1:0]  buf_data_q [2];
    logic [1:0]             buf_last_q;
    logic [1:0]             buf_final_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             cnt_q;
    logic [1:0]             cnt_d;

    logic [15:0]            beat_cnt_q;
    logic                   txdone_q;
    logic [DATA_WIDTH-1:0]  doutb_q;

    logic                   pop;
    logic                   pop_final;
    logic                   active;
    logic                   space_ok;
    logic                   rd_en;
    logic                   end_of_pass;
    logic                   last_pass;
    logic                   start_ok;

    assign pop         = (cnt_q != 2'd0) && m_axis_tready;
    assign pop_final   = pop && buf_final_q[rd_ptr_q];
    assign active      = (state_q == S_PREFETCH) || (state_q == S_STREAM);
    // A read issued now lands in the buffer two edges later; it may go out only
    // if the buffer cannot overflow even when the consumer stalls next cycle.
    assign space_ok    = ({1'b0, cnt_q} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop});
    assign rd_en       = active && !issue_done_q && space_ok;
    assign end_of_pass = ({1'b0, rd_addr_q} == (blen_q - BLEN_ONE));
    assign last_pass   = (pass_q == (niter_q - NITER_ONE));
    assign start_ok    = start && (niter != '0) && (block_len != '0);
    assign cnt_d       = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};

    // RAM array: read-first for both the port and the internal streaming read
    always_ff @(posedge m_axis_clk) begin
        if (enb && web) begin
            mem[addrb] <= dinb;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr_q];
        end
    end

    always_ff @(posedge m_axis_clk) begin
        if (master_rst) begin
            doutb_q <= '0;
        end else if (enb) begin
            doutb_q <= mem[addrb];
        end
    end

    // Control, read pipeline tags, skid buffer and FSM
    always_ff @(posedge m_axis_clk) begin
        if (master_rst) begin
            state_q       <= S_IDLE;
            niter_q       <= '0;
            blen_q        <= '0;
            pass_q        <= '0;
            rd_addr_q     <= '0;
            issue_done_q  <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_last_q     <= 1'b0;
            rd_final_q    <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q    <= '0;
            buf_final_q   <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= '0;
            beat_cnt_q    <= '0;
            txdone_q      <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            rd_last_q  <= end_of_pass;
            rd_final_q <= end_of_pass && last_pass;

            if (rd_en) begin
                if (end_of_pass) begin
                    rd_addr_q <= '0;
                    pass_q    <= pass_q + NITER_ONE;
                    if (last_pass) begin
                        issue_done_q <= 1'b1;
                    end
                end else begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                end
            end

            if (rd_vld_q) begin
                buf_data_q[wr_ptr_q]  <= rd_data_q;
                buf_last_q[wr_ptr_q]  <= rd_last_q;
                buf_final_q[wr_ptr_q] <= rd_final_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end
            cnt_q <= cnt_d;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        niter_q      <= niter;
                        blen_q       <= block_len;
                        pass_q       <= '0;
                        rd_addr_q    <= '0;
                        issue_done_q <= 1'b0;
                        beat_cnt_q   <= '0;
                        txdone_q     <= 1'b0;
                        state_q      <= S_PREFETCH;
                    end
                end
                S_PREFETCH: begin
                    if (rd_vld_q) begin
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (pop_final) begin
                        txdone_q <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign doutb         = doutb_q;
    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = buf_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && buf_last_q[rd_ptr_q];
    assign current_state = state_q;
    assign txram_counter = beat_cnt_q;
    assign txdone        = txdone_q;

endmodule

// File: tb/tb_ulbf_master_tx.sv
// Self-checking bench for ulbf_master_tx: a beat-queue model of the expected
// stream, checked every cycle, plus directed literal expectations.
module tb_ulbf_master_tx;

    logic         clk;
    logic         master_rst;
    logic         start;
    logic [11:0]  niter;
    logic [12:0]  block_len;
    logic         enb;
    logic         web;
    logic [11:0]  addrb;
    logic [63:0]  dinb;
    logic [63:0]  doutb;
    logic [63:0]  tdata;
    logic         tvalid;
    logic         tlast;
    logic         tready;
    logic [3:0]   current_state;
    logic [15:0]  txram_counter;
    logic         txdone;

    ulbf_master_tx dut (
        .m_axis_clk    (clk),
        .master_rst    (master_rst),
        .start         (start),
        .niter         (niter),
        .block_len     (block_len),
        .enb           (enb),
        .web           (web),
        .addrb         (addrb),
        .dinb          (dinb),
        .doutb         (doutb),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .current_state (current_state),
        .txram_counter (txram_counter),
        .txdone        (txdone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] ram_m [4096];
    logic [64:0] exp_q [$];
    logic [63:0] acc_data [$];
    bit          acc_last [$];
    int          total_beats;
    logic [15:0] model_cnt;
    bit          chk_en      = 1'b0;
    bit          expect_done = 1'b0;
    bit          done_seen   = 1'b0;
    bit          rnd_mode    = 1'b0;
    int          cyc         = 0;
    int          first_cyc;
    int          last_cyc;
    logic        prev_v, prev_r, prev_l;
    logic [63:0] prev_d;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endfunction

    // tready source: constant high or a coin toss each cycle
    initial begin
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: runs on the falling edge, away from the sampling edge
    initial begin
        prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) begin
                if (prev_v && !prev_r) begin
                    chk("hold_valid", 64'(tvalid), 64'd1);
                    if (tvalid) begin
                        chk("hold_data", tdata, prev_d);
                        chk("hold_last", 64'(tlast), 64'(prev_l));
                    end
                end
                chk("beat_counter", 64'(txram_counter), 64'(model_cnt));
                if (expect_done) begin
                    chk("done_valid", 64'(tvalid), 64'd0);
                    chk("done_state", 64'(current_state), 64'd3);
                    chk("done_flag", 64'(txdone), 64'd1);
                    expect_done = 1'b0;
                    done_seen   = 1'b1;
                    chk_en      = 1'b0;
                end else if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 64'd1, 64'd0);
                    end else begin
                        logic [64:0] e;
                        e = exp_q.pop_front();
                        chk("beat_data", tdata, e[63:0]);
                        chk("beat_last", 64'(tlast), 64'(e[64]));
                        if (acc_data.size() == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        acc_data.push_back(tdata);
                        acc_last.push_back(tlast);
                        model_cnt = model_cnt + 16'd1;
                        if (exp_q.size() == 0) expect_done = 1'b1;
                    end
                end
            end
            prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input int a, input logic [63:0] d);
        enb = 1'b1; web = 1'b1; addrb = 12'(a); dinb = d;
        tick();
        enb = 1'b0; web = 1'b0;
        ram_m[a] = d;
    endtask

    task automatic ram_read(input int a);
        enb = 1'b1; web = 1'b0; addrb = 12'(a);
        tick();
        enb = 1'b0;
    endtask

    task automatic pulse_start(input int n, input int b);
        niter = 12'(n); block_len = 13'(b); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic start_xfer(input int b, input int n, input bit rnd);
        exp_q.delete();
        acc_data.delete();
        acc_last.delete();
        for (int p = 0; p < n; p++)
            for (int i = 0; i < b; i++)
                exp_q.push_back({(i == b - 1), ram_m[i]});
        total_beats = b * n;
        model_cnt   = '0;
        done_seen   = 1'b0;
        expect_done = 1'b0;
        rnd_mode    = rnd;
        pulse_start(n, b);
        chk_en = 1'b1;
        chk("lat_prefetch", 64'(current_state), 64'd1);
        tick();
        chk("lat_valid_low", 64'(tvalid), 64'd0);
        tick();
        chk("lat_valid_high", 64'(tvalid), 64'd1);
        chk("lat_stream", 64'(current_state), 64'd2);
    endtask

    task automatic wait_done(input bit mid_start);
        int bound;
        bound = total_beats * 4 + 64;
        for (int c = 0; c < bound && !done_seen; c++) begin
            if (mid_start && c == 3) begin
                niter = 12'd5; block_len = 13'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        rnd_mode = 1'b0;
        if (!done_seen) begin
            chk("xfer_timeout", 64'd1, 64'd0);
            chk_en = 1'b0;
            master_rst = 1'b1;
            tick();
            master_rst = 1'b0;
        end
    endtask

    task automatic chk_gapless();
        chk("gap_free_span", 64'(last_cyc - first_cyc + 1), 64'(total_beats));
    endtask

    initial begin
        start = 1'b0; niter = '0; block_len = '0;
        enb = 1'b0; web = 1'b0; addrb = '0; dinb = '0;
        master_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        master_rst = 1'b0;
        chk("rst_valid", 64'(tvalid), 64'd0);
        chk("rst_last", 64'(tlast), 64'd0);
        chk("rst_data", tdata, 64'd0);
        chk("rst_done", 64'(txdone), 64'd0);
        chk("rst_counter", 64'(txram_counter), 64'd0);
        chk("rst_state", 64'(current_state), 64'd0);
        chk("rst_doutb", doutb, 64'd0);

        pulse_start(0, 4);
        chk("ign_niter0", 64'(current_state), 64'd0);
        pulse_start(1, 0);
        chk("ign_blen0", 64'(current_state), 64'd0);

        ram_write(7, 64'h1234);
        ram_read(7);
        chk("port_readback", doutb, 64'h1234);
        enb = 1'b1; web = 1'b1; addrb = 12'd7; dinb = 64'h5678;
        tick();
        enb = 1'b0; web = 1'b0;
        ram_m[7] = 64'h5678;
        chk("port_read_first", doutb, 64'h1234);
        tick();
        chk("port_hold", doutb, 64'h1234);
        ram_read(7);
        chk("port_new_data", doutb, 64'h5678);

        // Basic single pass
        for (int i = 0; i < 4; i++) ram_write(i, 64'hA0 + 64'(i));
        start_xfer(4, 1, 1'b0);
        wait_done(1'b0);
        chk_gapless();
        for (int i = 0; i < 4 && i < acc_data.size(); i++) begin
            chk("basic_data", acc_data[i], 64'hA0 + 64'(i));
            chk("basic_last", 64'(acc_last[i]), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("basic_count", 64'(txram_counter), 64'd4);
        chk("basic_txdone", 64'(txdone), 64'd1);

        pulse_start(0, 4);
        chk("ign_in_done_state", 64'(current_state), 64'd3);
        chk("ign_in_done_flag", 64'(txdone), 64'd1);

        // Repeated passes
        start_xfer(2, 3, 1'b0);
        wait_done(1'b0);
        chk_gapless();
        chk("rep_beats", 64'(acc_data.size()), 64'd6);
        for (int i = 0; i < 6 && i < acc_data.size(); i++) begin
            chk("rep_data", acc_data[i], (i % 2 == 1) ? 64'hA1 : 64'hA0);
            chk("rep_last", 64'(acc_last[i]), 64'(i % 2 == 1));
        end
        chk("rep_count", 64'(txram_counter), 64'd6);

        // Single-word block: tlast on every beat
        start_xfer(1, 3, 1'b0);
        wait_done(1'b0);
        for (int i = 0; i < acc_data.size(); i++)
            chk("len1_last", 64'(acc_last[i]), 64'd1);
        chk("len1_count", 64'(txram_counter), 64'd3);

        // Backpressure with a mid-stream start that must be ignored
        for (int i = 0; i < 16; i++) ram_write(i, 64'hC0DE_0000_0000_0000 | 64'(i));
        start_xfer(16, 2, 1'b1);
        wait_done(1'b1);
        chk("bp_beats", 64'(acc_data.size()), 64'd32);
        chk("bp_count", 64'(txram_counter), 64'd32);

        // Reset in the middle of a stream
        start_xfer(16, 2, 1'b0);
        for (int c = 0; c < 200 && acc_data.size() < 5; c++) tick();
        chk_en = 1'b0;
        master_rst = 1'b1;
        tick();
        master_rst = 1'b0;
        exp_q.delete();
        expect_done = 1'b0;
        chk("mrst_valid", 64'(tvalid), 64'd0);
        chk("mrst_state", 64'(current_state), 64'd0);
        chk("mrst_counter", 64'(txram_counter), 64'd0);
        chk("mrst_done", 64'(txdone), 64'd0);
        start_xfer(4, 1, 1'b0);
        wait_done(1'b0);
        if (acc_data.size() > 0) chk("mrst_restart_word0", acc_data[0], 64'hC0DE_0000_0000_0000);
        chk("mrst_restart_count", 64'(txram_counter), 64'd4);

        // Full-depth block, two passes
        for (int i = 0; i < 4096; i++) ram_write(i, 64'(i));
        start_xfer(4096, 2, 1'b0);
        wait_done(1'b0);
        chk_gapless();
        chk("full_beats", 64'(acc_data.size()), 64'd8192);
        if (acc_data.size() == 8192) begin
            chk("full_first", acc_data[0], 64'd0);
            chk("full_end_pass1", acc_data[4095], 64'd4095);
            chk("full_last_pass1", 64'(acc_last[4095]), 64'd1);
            chk("full_nolast_4094", 64'(acc_last[4094]), 64'd0);
            chk("full_restart", acc_data[4096], 64'd0);
            chk("full_last_pass2", 64'(acc_last[8191]), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
